rtc_persist_ctrl: RTL and testbench
===================================

// Module: rtc_persist_ctrl
// PURPOSE
//  Controller that sequences the 24-bit RTC seconds counter against the host save path.
//  On host restore it loads the RTC with saved seconds + elapsed host seconds.
//  It captures the counter coherently, on request or every SNAP_PERIOD RTC seconds.
//  It streams each capture as a 5-byte frame over valid/ready to the save buffer.
//  It sits between the RTC counter, already synchronised into clk, and the HPS save interface.
// PARAMETERS
//  SNAP_PERIOD  60    RTC seconds between automatic snapshots; 0 disables periodic snapshots
//  HDR_BYTE     8'h52 first byte of every snapshot frame
// PORTS
//  clk             in   1   system clock
//  reset           in   1   synchronous, active-high
//  ce              in   1   clock enable; all state, counters and handshakes advance only when ce=1
//  rtc_value       in   24  current RTC seconds, clk domain
//  rtc_tick        in   1   one-ce-cycle pulse when rtc_value increments
//  rtc_load        out  1   one-ce-cycle pulse: RTC takes rtc_load_value
//  rtc_load_value  out  24  value to load
//  restore_req     in   1   level; held by host until restore_ack
//  restore_seconds in   24  saved RTC seconds
//  restore_delta   in   32  host seconds elapsed since save
//  restore_ack     out  1   one-ce-cycle pulse: restore complete
//  snap_req        in   1   pulse: request a snapshot
//  snap_valid      out  1   frame byte valid
//  snap_data       out  8   frame byte
//  snap_last       out  1   marks the final (checksum) byte
//  snap_ready      in   1   sink accepts when snap_valid & snap_ready & ce
//  busy            out  1   high in any state except IDLE
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; snap_pend=0; period counter=0.
//  Reset mid-frame or mid-restore aborts it; no ack is issued and no byte is re-sent.
//  FSM states: IDLE, R_SUM, R_LOAD, R_ACK, S_CAP, S_SEND.
//  IDLE: restore_req=1 -> R_SUM. Else if snap_pend=1 -> S_CAP. Restore wins a tie.
//  R_SUM: sum = {8'h0,restore_seconds} + restore_delta, 32-bit. rtc_load_value <= sum[23:0],
//   so the result wraps mod 2^24.
//  R_LOAD: rtc_load=1 for this cycle; period counter cleared -> R_ACK.
//  R_ACK: restore_ack=1 for this cycle -> IDLE.
//   With ce=1 throughout: req seen in IDLE at N; rtc_load at N+2; ack at N+3.
//   If restore_req is still high in IDLE after the ack, a second restore starts.
//  S_CAP: if rtc_tick=1 this cycle, stay in S_CAP; capture is deferred so it never takes a
//   value that is changing. Otherwise latch cap=rtc_value, clear snap_pend -> S_SEND, byte idx 0.
//  S_SEND: the frame is HDR_BYTE, cap[7:0], cap[15:8], cap[23:16], chk.
//   chk = (cap[7:0]+cap[15:8]+cap[23:16]) mod 256.
//   snap_data and snap_last are stable while snap_valid=1 and snap_ready=0.
//   On a transfer the index advances and the next byte is valid in the following cycle,
//   so there are no bubbles. snap_last=1 only with chk. Transfer of chk -> IDLE, snap_valid=0.
//  snap_pend: set by snap_req=1, or by rtc_tick when period count == SNAP_PERIOD-1
//   (count then wraps to 0); SNAP_PERIOD=0 never sets it.
//   Requests are coalesced: any number of requests while snap_pend=1 or during S_SEND
//   gives exactly one further frame. A set in the same cycle as S_CAP's clear wins; pend stays 1.
//  Period counter: counts rtc_tick in every state; cleared in R_LOAD and on reset.
//  restore_req rising during S_SEND: the frame completes first; restore starts on return to IDLE.
//  ce=0: all registers hold; rtc_load and restore_ack are not re-emitted; handshake paused.
// TESTING
//  1 restore_seconds=24'h000100, restore_delta=32'h10 -> rtc_load_value=24'h000110, pulse at N+2,
//    restore_ack at N+3.
//  2 restore_seconds=24'hFFFFF0, delta=32'h01000020 -> rtc_load_value=24'h000010 (wrap).
//  3 rtc_value=24'h123456, snap_req, snap_ready=1 -> bytes 52,56,34,12,9C;
//    snap_last only on 9C; busy low after.
//  4 snap_ready toggled 1/0 each cycle during a frame -> same 5 bytes, data stable while stalled,
//    none duplicated or dropped.
//  5 SNAP_PERIOD=3, 7 rtc_ticks, no snap_req -> exactly 2 frames. rtc_tick coincident with S_CAP
//    -> captured value equals post-tick rtc_value.
//  6 restore_req and snap_req in same cycle -> restore first, then one frame. Reset after byte 2
//    -> snap_valid=0 next cycle, no further bytes, snap_pend=0.

Source files
------------

// File: rtl/rtc_persist_ctrl_if.sv
// Snapshot byte stream from the RTC persistence controller to the save buffer.
// Master drives valid/data/last, slave drives ready.
interface rtc_persist_ctrl_if;
    logic       snap_valid;
    logic [7:0] snap_data;
    logic       snap_last;
    logic       snap_ready;

    modport master (
        output snap_valid,
        output snap_data,
        output snap_last,
        input  snap_ready
    );

    modport slave (
        input  snap_valid,
        input  snap_data,
        input  snap_last,
        output snap_ready
    );
endinterface

// File: rtl/rtc_persist_ctrl.sv
// Sequences RTC restore (saved + elapsed seconds) and coherent RTC snapshots,
// streaming each snapshot as a 5-byte checksummed frame.
module rtc_persist_ctrl #(
    parameter int         SNAP_PERIOD = 60,
    parameter logic [7:0] HDR_BYTE    = 8'h52
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ce,
    input  logic [23:0]        rtc_value,
    input  logic               rtc_tick,
    output logic               rtc_load,
    output logic [23:0]        rtc_load_value,
    input  logic               restore_req,
    input  logic [23:0]        restore_seconds,
    input  logic [31:0]        restore_delta,
    output logic               restore_ack,
    input  logic               snap_req,
    rtc_persist_ctrl_if.master snap,
    output logic               busy
);
    localparam int PW = (SNAP_PERIOD > 1) ? $clog2(SNAP_PERIOD) : 1;

    typedef enum logic [2:0] {
        IDLE, R_SUM, R_LOAD, R_ACK, S_CAP, S_SEND
    } state_t;

    state_t         state, state_nx;
    logic [2:0]     idx, idx_nx;
    logic [23:0]    cap;
    logic           pend;
    logic [PW-1:0]  per_cnt;
    logic [31:0]    sum;
    logic [7:0]     chk;
    logic           per_hit;
    logic           cap_take;
    logic           xfer;
    logic           unused_sum_hi;

    assign sum           = {8'h0, restore_seconds} + restore_delta;
    assign unused_sum_hi = ^sum[31:24];
    assign chk           = cap[7:0] + cap[15:8] + cap[23:16];
    assign per_hit       = (SNAP_PERIOD != 0) && rtc_tick
                           && (per_cnt == PW'(SNAP_PERIOD - 1));
    assign xfer          = snap.snap_valid & snap.snap_ready;

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        cap_take = 1'b0;
        unique case (state)
            IDLE: begin
                if (restore_req)
                    state_nx = R_SUM;
                else if (pend)
                    state_nx = S_CAP;
            end
            R_SUM:  state_nx = R_LOAD;
            R_LOAD: state_nx = R_ACK;
            R_ACK:  state_nx = IDLE;
            // A tick this cycle means rtc_value is mid-change; wait it out.
            S_CAP: begin
                if (!rtc_tick) begin
                    cap_take = 1'b1;
                    idx_nx   = 3'd0;
                    state_nx = S_SEND;
                end
            end
            S_SEND: begin
                if (xfer) begin
                    if (idx == 3'd4)
                        state_nx = IDLE;
                    else
                        idx_nx = idx + 3'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        snap.snap_data = HDR_BYTE;
        unique case (idx)
            3'd1:    snap.snap_data = cap[7:0];
            3'd2:    snap.snap_data = cap[15:8];
            3'd3:    snap.snap_data = cap[23:16];
            3'd4:    snap.snap_data = chk;
            default: snap.snap_data = HDR_BYTE;
        endcase
    end

    assign snap.snap_valid = (state == S_SEND);
    assign snap.snap_last  = (state == S_SEND) && (idx == 3'd4);
    assign rtc_load        = ce && (state == R_LOAD);
    assign restore_ack     = ce && (state == R_ACK);
    assign busy            = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            idx            <= 3'd0;
            cap            <= 24'h0;
            pend           <= 1'b0;
            per_cnt        <= '0;
            rtc_load_value <= 24'h0;
        end else if (ce) begin
            state <= state_nx;
            idx   <= idx_nx;
            if (cap_take)
                cap <= rtc_value;
            if (state == R_SUM)
                rtc_load_value <= sum[23:0];
            // A new request in the capture cycle must survive the clear.
            if (snap_req || per_hit)
                pend <= 1'b1;
            else if (cap_take)
                pend <= 1'b0;
            if (state == R_LOAD)
                per_cnt <= '0;
            else if (rtc_tick)
                per_cnt <= per_hit ? '0 : per_cnt + PW'(1);
        end
    end
endmodule

// File: tb/tb_rtc_persist_ctrl.sv
// Randomized + directed bench for rtc_persist_ctrl against a queue-based
// transaction model of restore and snapshot behaviour.
module tb_rtc_persist_ctrl;
    localparam int         SP  = 3;
    localparam logic [7:0] HDR = 8'h52;

    logic        clk = 1'b0;
    logic        reset, ce, rtc_tick, rtc_load;
    logic        restore_req, restore_ack, snap_req, busy;
    logic [23:0] rtc_value, rtc_load_value, restore_seconds;
    logic [31:0] restore_delta;

    rtc_persist_ctrl_if sif ();

    rtc_persist_ctrl #(.SNAP_PERIOD(SP), .HDR_BYTE(HDR)) dut (
        .clk             (clk),
        .reset           (reset),
        .ce              (ce),
        .rtc_value       (rtc_value),
        .rtc_tick        (rtc_tick),
        .rtc_load        (rtc_load),
        .rtc_load_value  (rtc_load_value),
        .restore_req     (restore_req),
        .restore_seconds (restore_seconds),
        .restore_delta   (restore_delta),
        .restore_ack     (restore_ack),
        .snap_req        (snap_req),
        .snap            (sif.master),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // model: restore phase (0 none, 1 summing, 2 loading, 3 acking),
    // capture wanted, and the bytes still owed of the current frame
    int          rs;
    bit          cw;
    bit [7:0]    q[$];
    bit          pend;
    int          per;
    logic [23:0] m_lv;
    logic [23:0] m_rtc;
    int          cyc;

    logic [7:0]  got_d[$];
    bit          got_l[$];
    int          got_c[$];
    int          load_cyc, ack_cyc;
    logic [23:0] load_val;
    bit          ack_seen;

    function automatic void check(string name, logic [31:0] act,
                                  logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endfunction

    task automatic model_advance();
        bit          hit;
        bit          set;
        bit          clr;
        logic [23:0] nx;
        logic [23:0] c;
        if (reset) begin
            rs   = 0;
            cw   = 0;
            q.delete();
            pend = 0;
            per  = 0;
            m_lv = 24'h0;
        end else if (ce) begin
            hit = rtc_tick && (per == SP - 1);
            set = snap_req || hit;
            clr = 0;
            nx  = m_rtc;
            if (rs == 2) nx = m_lv;
            else if (rtc_tick) nx = m_rtc + 24'd1;
            if (rs == 2) per = 0;
            else if (rtc_tick) per = hit ? 0 : per + 1;
            if (rs == 1) begin
                m_lv = 24'(restore_delta + 32'(restore_seconds));
                rs   = 2;
            end else if (rs == 2) begin
                rs = 3;
            end else if (rs == 3) begin
                rs = 0;
            end else if (cw) begin
                if (!rtc_tick) begin
                    c = m_rtc;
                    q.push_back(HDR);
                    q.push_back(c[7:0]);
                    q.push_back(c[15:8]);
                    q.push_back(c[23:16]);
                    q.push_back(8'((c[7:0] + c[15:8] + c[23:16]) % 256));
                    cw  = 0;
                    clr = 1;
                end
            end else if (q.size() != 0) begin
                if (sif.snap_ready) void'(q.pop_front());
            end else if (restore_req) begin
                rs = 1;
            end else if (pend) begin
                cw = 1;
            end
            pend  = set ? 1'b1 : (clr ? 1'b0 : pend);
            m_rtc = nx;
        end
    endtask

    task automatic step();
        @(negedge clk);
        check("busy", busy, (rs != 0 || cw || q.size() != 0));
        check("rtc_load", rtc_load, (ce && rs == 2));
        check("restore_ack", restore_ack, (ce && rs == 3));
        check("rtc_load_value", rtc_load_value, m_lv);
        check("snap_valid", sif.snap_valid, (q.size() != 0));
        check("snap_last", sif.snap_last, (q.size() == 1));
        if (q.size() != 0)
            check("snap_data", sif.snap_data, q[0]);
        if (!reset && ce && rtc_load) begin
            load_cyc = cyc;
            load_val = rtc_load_value;
        end
        ack_seen = !reset && ce && restore_ack;
        if (ack_seen) ack_cyc = cyc;
        if (!reset && ce && sif.snap_valid && sif.snap_ready) begin
            got_d.push_back(sif.snap_data);
            got_l.push_back(sif.snap_last);
            got_c.push_back(cyc);
        end
        model_advance();
        @(posedge clk);
        #1;
        cyc++;
        rtc_value = m_rtc;
    endtask

    task automatic clear_log();
        got_d.delete();
        got_l.delete();
        got_c.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
    endtask

    task automatic restore(input logic [23:0] s, input logic [31:0] d,
                           input logic [23:0] exp_v, input string tag);
        int rc;
        restore_seconds = s;
        restore_delta   = d;
        restore_req     = 1'b1;
        rc              = cyc;
        load_cyc        = -1;
        ack_cyc         = -1;
        repeat (4) step();
        restore_req = 1'b0;
        step();
        check({tag, "_value"}, load_val, exp_v);
        check({tag, "_load_cyc"}, load_cyc - rc, 2);
        check({tag, "_ack_cyc"}, ack_cyc - rc, 3);
    endtask

    task automatic check_frame(input logic [23:0] v, input int base,
                               input string tag);
        logic [7:0] b [5];
        b[0] = HDR;
        b[1] = v[7:0];
        b[2] = v[15:8];
        b[3] = v[23:16];
        b[4] = v[7:0] + v[15:8] + v[23:16];
        check({tag, "_count"}, got_d.size(), base + 5);
        if (got_d.size() >= base + 5) begin
            for (int i = 0; i < 5; i++) begin
                check({tag, "_byte"}, got_d[base + i], b[i]);
                check({tag, "_last"}, got_l[base + i], (i == 4));
            end
        end
    endtask

    initial begin
        int          n_last;
        int          budget;
        logic [23:0] v;

        reset           = 1'b1;
        ce              = 1'b1;
        rtc_tick        = 1'b0;
        restore_req     = 1'b0;
        restore_seconds = 24'h0;
        restore_delta   = 32'h0;
        snap_req        = 1'b0;
        sif.snap_ready  = 1'b0;
        rtc_value       = 24'h0;
        m_rtc           = 24'h0;
        m_lv            = 24'h0;
        cyc             = 0;
        load_val        = 24'h0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        reset = 1'b1;
        step();
        check("rst_busy", busy, 0);
        check("rst_valid", sif.snap_valid, 0);
        check("rst_load", rtc_load, 0);
        check("rst_load_value", rtc_load_value, 0);
        check("rst_ack", restore_ack, 0);
        reset = 1'b0;
        step();

        restore(24'h000100, 32'h10, 24'h000110, "restore1");
        restore(24'hFFFFF0, 32'h01000020, 24'h000010, "restore_wrap");

        clear_log();
        m_rtc          = 24'h123456;
        rtc_value      = m_rtc;
        sif.snap_ready = 1'b1;
        snap_req       = 1'b1;
        step();
        snap_req = 1'b0;
        repeat (10) step();
        check_frame(24'h123456, 0, "frame");
        if (got_d.size() == 5) check("frame_chk", got_d[4], 8'h9C);
        check("frame_busy_after", busy, 0);

        clear_log();
        snap_req = 1'b1;
        step();
        snap_req = 1'b0;
        for (int i = 0; i < 20; i++) begin
            sif.snap_ready = i[0];
            step();
        end
        sif.snap_ready = 1'b1;
        repeat (4) step();
        check_frame(24'h123456, 0, "stall_frame");

        do_reset();
        clear_log();
        for (int i = 0; i < 7; i++) begin
            rtc_tick = 1'b1;
            step();
            rtc_tick = 1'b0;
            repeat (3) step();
        end
        repeat (15) step();
        n_last = 0;
        foreach (got_l[i]) n_last += int'(got_l[i]);
        check("period_frames", n_last, 2);

        clear_log();
        v        = m_rtc + 24'd1;
        snap_req = 1'b1;
        step();
        snap_req = 1'b0;
        step();
        rtc_tick = 1'b1;
        step();
        rtc_tick = 1'b0;
        repeat (10) step();
        check_frame(v, 0, "tick_cap");

        do_reset();
        clear_log();
        restore_seconds = 24'h00ABCD;
        restore_delta   = 32'h5;
        restore_req     = 1'b1;
        snap_req        = 1'b1;
        ack_cyc         = -1;
        step();
        snap_req = 1'b0;
        budget   = 20;
        while (!ack_seen && budget > 0) begin
            step();
            budget--;
        end
        check("tie_ack_timeout", (budget > 0), 1);
        restore_req = 1'b0;
        repeat (12) step();
        check("tie_frame_count", got_d.size(), 5);
        if (got_c.size() != 0)
            check("tie_restore_first", (got_c[0] > ack_cyc), 1);

        clear_log();
        snap_req = 1'b1;
        step();
        snap_req = 1'b0;
        budget   = 30;
        while (got_d.size() < 2 && budget > 0) begin
            step();
            budget--;
        end
        check("abort_wait_timeout", (budget > 0), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_valid", sif.snap_valid, 0);
        repeat (10) step();
        check("abort_no_more", got_d.size(), 2);

        for (int i = 0; i < 3000; i++) begin
            ce             = ($urandom % 8) != 0;
            rtc_tick       = ce && ($urandom % 6) == 0;
            snap_req       = ($urandom % 25) == 0;
            sif.snap_ready = ($urandom % 3) != 0;
            reset          = ($urandom % 500) == 0;
            if (restore_req && ack_seen && ($urandom % 10) < 7)
                restore_req = 1'b0;
            else if (!restore_req && ($urandom % 60) == 0) begin
                restore_seconds = 24'($urandom);
                restore_delta   = $urandom;
                restore_req     = 1'b1;
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
